// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader feeding the MC14500B program-memory
// write port. Frame = SYNC_BYTE, LEN, LEN x (CMD_HI, CMD_LO) [, CHK].
// The CPU is held in reset from SYNC until a frame completes cleanly.
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (XOR of LEN and every command byte) that must match for the frame to load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | hunting for SYNC_BYTE, other bytes discarded
// S_LEN    | expecting the instruction count byte
// S_CMD_HI | expecting the high byte of an instruction word
// S_CMD_LO | expecting the low byte; acceptance issues a write next cycle
// S_CHK    | expecting the checksum byte (checksum build only)
// S_FIN    | one-cycle wrap-up, input stalled; reports done or error
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CMD_WIDTH  = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  program_write,
  output logic [ADDR_WIDTH-1:0] program_addr,
  output logic [CMD_WIDTH-1:0]  program_cmd,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
  localparam int unsigned MAX_LEN  = 1 << ADDR_WIDTH;
  localparam int unsigned TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_CMD_HI,
    S_CMD_LO,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic                  accept;
  logic                  active;
  logic                  timed_out;
  logic                  len_bad;
  logic                  last_word;
  logic [TMR_W-1:0]      tmr_q;
  logic [CNT_W-1:0]      rem_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [7:0]            hi_q;
  logic [CMD_WIDTH-1:0]  word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
  logic                  chk_ok_q;
`endif

  // Handshake and frame-condition decode shared by FSM and datapath.
  always_comb begin
    in_ready  = (state_q != S_FIN);
    accept    = in_valid && in_ready;
    active    = (state_q != S_IDLE) && (state_q != S_FIN);
    timed_out = active && !accept && (tmr_q == '0);
    len_bad   = (in_data == 8'd0) || (32'(in_data) > MAX_LEN);
    last_word = (rem_q == CNT_W'(1));
    word      = CMD_WIDTH'({hi_q, in_data});
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a timeout overrides any other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && in_data == SYNC_BYTE) state_d = S_LEN;
      S_LEN:    if (accept) state_d = len_bad ? S_IDLE : S_CMD_HI;
      S_CMD_HI: if (accept) state_d = S_CMD_LO;
      S_CMD_LO: begin
        if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = last_word ? S_CHK : S_CMD_HI;
`else
          state_d = last_word ? S_FIN : S_CMD_HI;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK:    if (accept) state_d = S_FIN;
`endif
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (timed_out) state_d = S_IDLE;
  end

  // Datapath: idle timer, word counters, write port and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q         <= '0;
      rem_q         <= '0;
      idx_q         <= '0;
      hi_q          <= '0;
      program_write <= 1'b0;
      program_addr  <= '0;
      program_cmd   <= '0;
      cpu_reset     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q        <= '0;
      chk_ok_q      <= 1'b0;
`endif
    end else begin
      program_write <= 1'b0;
      done          <= 1'b0;

      if (accept)                        tmr_q <= TMR_LOAD;
      else if (active && tmr_q != '0)    tmr_q <= tmr_q - 1'b1;

      if (timed_out) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (len_bad) begin
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              rem_q  <= CNT_W'(in_data);
              idx_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              csum_q <= in_data;
`endif
            end
          end
        end
        S_CMD_HI: begin
          if (accept) begin
            hi_q   <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end
        end
        S_CMD_LO: begin
          if (accept) begin
            program_write <= 1'b1;
            program_addr  <= idx_q;
            program_cmd   <= word;
            idx_q         <= idx_q + 1'b1;
            rem_q         <= rem_q - 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q        <= csum_q ^ in_data;
`endif
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) chk_ok_q <= (in_data == csum_q);
        end
`endif
        S_FIN: begin
          busy <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (chk_ok_q) begin
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            error     <= 1'b1;
          end
`else
          done      <= 1'b1;
          cpu_reset <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that sits directly upstream of the MC14500B wrapper and drives its program-memory write port. It accepts a framed byte stream over a valid/ready handshake, unpacks instruction words, and issues one write strobe per instruction with a sequential address. The CPU is held in reset for the whole frame and is released only after a frame completes without error.

## Interface
- `ADDR_WIDTH`, 8: program address width; 1..8.
- `CMD_WIDTH`, 12: instruction word width (4-bit opcode + operand); 1..16.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT`, 1000: max idle cycles between accepted bytes inside a frame; ≥1.
- `clk  in  1  system clock; all state on rising edge`
- `reset  in  1  asynchronous, active-low reset`
- `in_data  in  8  stream byte`
- `in_valid  in  1  in_data valid`
- `in_ready  out  1  loader can accept; byte transfers when in_valid & in_ready at rising edge`
- `program_write  out  1  one-cycle write strobe to wrapper`
- `program_addr  out  ADDR_WIDTH  write address`
- `program_cmd  out  CMD_WIDTH  instruction word`
- `cpu_reset  out  1  active-high hold for wrapper reset`
- `busy  out  1  frame in progress`
- `done  out  1  one-cycle pulse: frame loaded successfully`
- `error  out  1  sticky frame error`

## Operation
- Frame: SYNC_BYTE, LEN, LEN × (CMD_HI, CMD_LO), [CHK when checksum compiled in].
- States: IDLE, LEN, CMD_HI, CMD_LO, CHK (macro only), FIN.
- IDLE: bytes ≠ SYNC_BYTE discarded, no flag change. SYNC_BYTE → LEN; error cleared, cpu_reset=1, busy=1.
- LEN: value 0 or > 2**ADDR_WIDTH → error=1, IDLE (cpu_reset stays 1). Else latch count, clear index and checksum, → CMD_HI.
- CMD_HI → CMD_LO. On CMD_LO accept: word = {CMD_HI,CMD_LO}[CMD_WIDTH-1:0]; upper bits ignored; registered write issued next cycle at address = index; index++.
- After last CMD_LO: → CHK if macro defined, else → FIN.
- FIN: one cycle, in_ready=0; then IDLE with done=1, cpu_reset=0, busy=0.
- Timeout: any non-IDLE, non-FIN state with TIMEOUT consecutive cycles without an accepted byte → error=1, IDLE, cpu_reset stays 1. Counter resets on every accepted byte.
- cpu_reset deasserts only on successful completion; an error leaves the CPU held until a later good frame.
- Reset mid-frame: all state to reset values immediately; partial writes already issued are not undone.

## Timing
- Reset values: in_ready=1, program_write=0, program_addr=0, program_cmd=0, cpu_reset=0, busy=0, done=0, error=0; state IDLE.
- in_ready=1 in all states except FIN and while reset is asserted.
- Max throughput one byte per cycle; no back-pressure outside FIN.
- CMD_LO accepted at edge t → program_write=1, addr/cmd valid during cycle t+1; addr/cmd hold until next write.
- Without checksum: last CMD_LO at t → write at t+1 (FIN) → done pulse, cpu_reset=0 at t+2.
- With checksum: CHK at t → FIN at t+1 → done or error at t+2.
- SYNC_BYTE accepted at t → cpu_reset=1, busy=1 from t+1.
- error sets the cycle after the offending byte/timeout; clears the cycle after a SYNC_BYTE is accepted.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: frame carries trailing CHK byte; checksum = XOR of LEN and all command bytes; CHK ≠ checksum → error=1 instead of done, cpu_reset stays 1; CHK is subject to timeout.
- Undefined: no CHK state or byte; frame ends after last CMD_LO; checksum logic absent.

## Test plan
- Frame A5,02,01,23,0F,FF (no macro) → writes addr0=0x123, addr1=0xFFF on consecutive-odd cycles; done 2 cycles after last byte; cpu_reset 1→0.
- Garbage 00,FF,5A before A5,01,00,07 → garbage ignored, single write addr0=0x007, done=1, error=0.
- LEN=00 after sync → error=1, no writes, cpu_reset stays 1; next valid frame clears error and releases.
- Stall TIMEOUT cycles after CMD_HI → error=1 exactly at TIMEOUT, state IDLE, no write for that word.
- Macro on: A5,01,12,34,CHK=0x27 → write 0x234, done; same frame with CHK=0x00 → error=1, cpu_reset=1.
- Assert reset (low) mid-frame after 1 write → all outputs to reset values asynchronously; fresh frame after release loads normally.
